// File: rtl/pio_led_arbiter.sv
// Round-robin arbiter that shares the LED output register between N_REQ requesters,
// with a minimum display time after each write and a synchronised switch bank.
module pio_led_arbiter #(
    parameter int N_REQ       = 2,
    parameter int WIDTH       = 10,
    parameter int HOLD_CYCLES = 4,
    parameter int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       led_o,
    output logic [ID_W-1:0]        owner_o,
    output logic                   busy_o,
    input  logic [WIDTH-1:0]       sw_i,
    output logic [WIDTH-1:0]       sw_sync_o,
    output logic                   sw_change_o
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_next;
    logic [7:0]      hold_cnt;
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    function automatic logic [ID_W-1:0] wrap_idx(input int v);
        return ID_W'(v % N_REQ);
    endfunction

    // Search starts at ptr and wraps, so the first valid requester after the last winner wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        req_ready   = '0;
        if (!reset && state == IDLE) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!grant_found && req_valid[wrap_idx(int'(ptr) + k)]) begin
                    grant_found = 1'b1;
                    grant_idx   = wrap_idx(int'(ptr) + k);
                end
            end
        end
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_found && HOLD_CYCLES > 0) state_next = HOLD;
            HOLD: if (hold_cnt == 8'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_o    <= '0;
            owner_o  <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_found) begin
                led_o    <= req_data[int'(grant_idx)*WIDTH +: WIDTH];
                owner_o  <= grant_idx;
                ptr      <= ptr_next;
                hold_cnt <= HOLD_INIT;
            end
        end else begin
            hold_cnt <= hold_cnt - 8'd1;
        end
    end

    assign busy_o = (state == HOLD);

    // Two-flop synchroniser; the change pulse lines up with the first cycle of the new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= '0;
            s2          <= '0;
            sw_change_o <= 1'b0;
        end else begin
            s1          <= sw_i;
            s2          <= s1;
            sw_change_o <= (s1 != s2);
        end
    end

    assign sw_sync_o = s2;

endmodule

// File: tb/tb_pio_led_arbiter.sv
// Directed self-checking bench for pio_led_arbiter: one instance with the default
// hold time and one with HOLD_CYCLES=0 for back-to-back grants.
module tb_pio_led_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [19:0] req_data;
    logic [1:0]  req_ready;
    logic [9:0]  led_o;
    logic [0:0]  owner_o;
    logic        busy_o;
    logic [9:0]  sw_i;
    logic [9:0]  sw_sync_o;
    logic        sw_change_o;

    logic [1:0]  req_valid0;
    logic [19:0] req_data0;
    logic [1:0]  req_ready0;
    logic [9:0]  led_o0;
    logic [0:0]  owner_o0;
    logic        busy_o0;
    logic [9:0]  sw_sync_o0;
    logic        sw_change_o0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_led_arbiter #(.N_REQ(2), .WIDTH(10), .HOLD_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .led_o(led_o), .owner_o(owner_o), .busy_o(busy_o),
        .sw_i(sw_i), .sw_sync_o(sw_sync_o), .sw_change_o(sw_change_o)
    );

    pio_led_arbiter #(.N_REQ(2), .WIDTH(10), .HOLD_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_data(req_data0),
        .req_ready(req_ready0), .led_o(led_o0), .owner_o(owner_o0), .busy_o(busy_o0),
        .sw_i(sw_i), .sw_sync_o(sw_sync_o0), .sw_change_o(sw_change_o0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b11;
        req_data   = {10'h2CC, 10'h0AA};
        req_valid0 = 2'b00;
        req_data0  = {10'h2CC, 10'h0AA};
        sw_i       = 10'h3FF;

        // Reset holds everything at zero even with requests and switches active
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_led", 32'(led_o), 32'h0);
            checkOutput("rst_ready", 32'(req_ready), 32'h0);
            checkOutput("rst_busy", 32'(busy_o), 32'h0);
            checkOutput("rst_sw_sync", 32'(sw_sync_o), 32'h0);
            checkOutput("rst_sw_change", 32'(sw_change_o), 32'h0);
        end

        // Single write from requester 1
        reset     = 1'b0;
        sw_i      = 10'h000;
        req_valid = 2'b10;
        req_data  = {10'h155, 10'h0AA};
        #1;
        checkOutput("single_ready", 32'(req_ready), 32'h2);
        checkOutput("single_busy_pre", 32'(busy_o), 32'h0);
        tick();
        req_valid = 2'b00;
        checkOutput("single_led", 32'(led_o), 32'h155);
        checkOutput("single_owner", 32'(owner_o), 32'h1);
        checkOutput("single_busy1", 32'(busy_o), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("single_busy_hold", 32'(busy_o), 32'h1);
            checkOutput("single_ready_hold", 32'(req_ready), 32'h0);
        end
        tick();
        checkOutput("single_busy_end", 32'(busy_o), 32'h0);

        // Round robin with both requesters valid, grants every 5 cycles
        req_valid = 2'b11;
        req_data  = {10'h2CC, 10'h0AA};
        #1;
        checkOutput("rr_ready0", 32'(req_ready), 32'h1);
        tick();
        checkOutput("rr_led0", 32'(led_o), 32'h0AA);
        checkOutput("rr_owner0", 32'(owner_o), 32'h0);
        for (int r = 1; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("rr_ready_hold", 32'(req_ready), 32'h0);
                tick();
            end
            checkOutput("rr_ready", 32'(req_ready), (r % 2 == 1) ? 32'h2 : 32'h1);
            tick();
            checkOutput("rr_led", 32'(led_o), (r % 2 == 1) ? 32'h2CC : 32'h0AA);
            checkOutput("rr_owner", 32'(owner_o), (r % 2 == 1) ? 32'h1 : 32'h0);
        end
        req_valid = 2'b00;

        // Zero hold time: a grant every cycle, alternating owners
        req_valid0 = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("h0_ready", 32'(req_ready0), (i % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput("h0_busy", 32'(busy_o0), 32'h0);
            tick();
            checkOutput("h0_led", 32'(led_o0), (i % 2 == 0) ? 32'h0AA : 32'h2CC);
        end
        req_valid0 = 2'b00;

        // Let the main instance drain back to IDLE
        for (int i = 0; i < 5; i++) tick();
        checkOutput("drain_busy", 32'(busy_o), 32'h0);

        // Reset in the second HOLD cycle discards state; waiting requester 1 wins after release
        req_valid = 2'b01;
        req_data  = {10'h2CC, 10'h3FF};
        tick();
        checkOutput("mid_led", 32'(led_o), 32'h3FF);
        checkOutput("mid_busy", 32'(busy_o), 32'h1);
        tick();
        reset     = 1'b1;
        req_valid = 2'b10;
        tick();
        checkOutput("mid_rst_led", 32'(led_o), 32'h0);
        checkOutput("mid_rst_busy", 32'(busy_o), 32'h0);
        checkOutput("mid_rst_owner", 32'(owner_o), 32'h0);
        reset = 1'b0;
        #1;
        checkOutput("mid_rel_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        checkOutput("mid_rel_led", 32'(led_o), 32'h2CC);
        checkOutput("mid_rel_owner", 32'(owner_o), 32'h1);
        checkOutput("mid_rel_busy", 32'(busy_o), 32'h1);

        // Switch path: change just after edge k
        sw_i = 10'h201;
        tick();
        checkOutput("sw_k1_sync", 32'(sw_sync_o), 32'h0);
        checkOutput("sw_k1_change", 32'(sw_change_o), 32'h0);
        tick();
        checkOutput("sw_k2_sync", 32'(sw_sync_o), 32'h201);
        checkOutput("sw_k2_change", 32'(sw_change_o), 32'h1);
        tick();
        checkOutput("sw_k3_sync", 32'(sw_sync_o), 32'h201);
        checkOutput("sw_k3_change", 32'(sw_change_o), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("sw_static_change", 32'(sw_change_o), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
